// File: rtl/shift_deser_pkg.sv
// +--------------------------------------------------------------------------
// | shift_deser_pkg : shared FSM encoding and default word width
// | Rev 1.0
// +--------------------------------------------------------------------------
`default_nettype none

package shift_deser_pkg;

  localparam int c_width_default = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/deser_shift_core.sv
// +--------------------------------------------------------------------------
// | deser_shift_core : order-aware shift register and bit counter
// | Rev 1.0
// +--------------------------------------------------------------------------
`default_nettype none

module deser_shift_core
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = c_width_default
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_en,
  input  logic                         restart,
  input  logic                         order,
  input  logic                         bit_in,
  output logic [WIDTH-1:0]             word,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int                 c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  logic [WIDTH-1:0]   r_sr;
  logic [c_cnt_w-1:0] r_count;
  logic               r_order;

  logic [WIDTH-1:0]   w_base;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_ord;
  logic               w_last;

  // A restart builds on an empty register with the freshly sampled order.
  assign w_base    = restart ? '0 : r_sr;
  assign w_ord     = restart ? order : r_order;
  assign w_shifted = w_ord ? {bit_in, w_base[WIDTH-1:1]}
                           : {w_base[WIDTH-2:0], bit_in};
  assign w_last    = shift_en && !restart && (r_count == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr    <= '0;
      r_count <= '0;
      r_order <= 1'b0;
    end else if (restart) begin
      r_sr    <= w_shifted;
      r_count <= c_cnt_w'(1);
      r_order <= order;
    end else if (shift_en) begin
      if (w_last) begin
        r_sr    <= '0;
        r_count <= '0;
      end else begin
        r_sr    <= w_shifted;
        r_count <= r_count + c_cnt_w'(1);
      end
    end
  end

  // Word as it stands including the bit presented this cycle, so the
  // parent can capture a completed word on the very edge of its last bit.
  assign word  = w_shifted;
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/shift_deser.sv
// +--------------------------------------------------------------------------
// | shift_deser : framed serial-to-parallel deserializer with sticky errors
// | Rev 1.0
// +--------------------------------------------------------------------------
`default_nettype none

module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = c_width_default
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sval,
  input  logic             sof,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  input  logic             clr_err,
  output logic             overrun,
  output logic             frame_err
);

  localparam int                 c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_dout;
  logic               r_dout_valid;
  logic               r_overrun;
  logic               r_frame_err;

  logic [WIDTH-1:0]   w_word;
  logic [c_cnt_w-1:0] w_count;
  logic               w_restart;
  logic               w_shift;
  logic               w_done;
  logic               w_can_load;
  logic               w_fe_set;
  logic               w_ov_set;

  assign w_restart  = sval && sof;
  assign w_shift    = sval && !sof && (r_state == RECV);
  assign w_done     = w_shift && (w_count == c_last);
  assign w_can_load = !r_dout_valid || dout_ready;
  assign w_fe_set   = w_restart && (r_state == RECV);
  assign w_ov_set   = w_done && !w_can_load;

  deser_shift_core #(
    .WIDTH    (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_shift),
    .restart  (w_restart),
    .order    (lsb_first),
    .bit_in   (sin),
    .word     (w_word),
    .count    (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_restart)
        r_state <= RECV;
      else if (w_done)
        r_state <= IDLE;

      if (w_done && w_can_load) begin
        r_dout       <= w_word;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end

      // Set events win over a simultaneous clear.
      if (w_ov_set)
        r_overrun <= 1'b1;
      else if (clr_err)
        r_overrun <= 1'b0;

      if (w_fe_set)
        r_frame_err <= 1'b1;
      else if (clr_err)
        r_frame_err <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;
  assign frame_err  = r_frame_err;

endmodule

`default_nettype wire
